retire_serializer: RTL and testbench

//  Parametrised commit-port serializer between the CPU retire stage and trace_encoder.
//  - Each cycle it captures up to NR_PORTS retired uops, plus the common cause/tval/priv.
//  - Captured uops go into one shared slot FIFO (one slot per capture cycle).
//  - Drains one uop per cycle under a valid/ready handshake, skipping ports that carry nothing.
//  - Flags lost captures with a sticky overflow flag and a saturating drop counter.

---
 rtl/retire_serializer.sv | 171 +++++++++++++++++
 tb/tb_retire_serializer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_serializer.sv
// Serialises up to NR_PORTS retired uops per cycle into a single uop stream for trace_encoder.
// One FIFO slot per capture cycle; drains the active ports of the head slot one per cycle.
module retire_serializer #(
    parameter int unsigned NR_PORTS      = 2,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned ITYPE_LEN     = 3,
    parameter int unsigned ILASTSIZE_LEN = 1,
    parameter int unsigned CAUSE_LEN     = 5,
    parameter int unsigned TVAL_LEN      = 64,
    parameter int unsigned PRIV_LEN      = 2,
    parameter int unsigned DROP_CNT_LEN  = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NR_PORTS-1:0]               iretire_i,
    input  logic [NR_PORTS*ILASTSIZE_LEN-1:0] ilastsize_i,
    input  logic [NR_PORTS*ITYPE_LEN-1:0]     itype_i,
    input  logic [NR_PORTS*XLEN-1:0]          iaddr_i,
    input  logic [CAUSE_LEN-1:0]              cause_i,
    input  logic [TVAL_LEN-1:0]               tval_i,
    input  logic [PRIV_LEN-1:0]               priv_i,
    output logic                              ready_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic                              iretire_o,
    output logic [ILASTSIZE_LEN-1:0]          ilastsize_o,
    output logic [ITYPE_LEN-1:0]              itype_o,
    output logic [XLEN-1:0]                   iaddr_o,
    output logic [CAUSE_LEN-1:0]              cause_o,
    output logic [TVAL_LEN-1:0]               tval_o,
    output logic [PRIV_LEN-1:0]               priv_o,
    input  logic                              clear_ovf_i,
    output logic                              overflow_o,
    output logic [DROP_CNT_LEN-1:0]           drop_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned UW = AW + 1;
    localparam logic [UW-1:0] FULL_CNT = UW'(DEPTH);

    // Slot storage: all ports, their active mask and the common fields of one capture cycle.
    logic [NR_PORTS-1:0]               mem_ret_q   [DEPTH];
    logic [NR_PORTS-1:0]               mem_mask_q  [DEPTH];
    logic [NR_PORTS*ILASTSIZE_LEN-1:0] mem_ils_q   [DEPTH];
    logic [NR_PORTS*ITYPE_LEN-1:0]     mem_itype_q [DEPTH];
    logic [NR_PORTS*XLEN-1:0]          mem_iaddr_q [DEPTH];
    logic [CAUSE_LEN-1:0]              mem_cause_q [DEPTH];
    logic [TVAL_LEN-1:0]               mem_tval_q  [DEPTH];
    logic [PRIV_LEN-1:0]               mem_priv_q  [DEPTH];

    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [UW-1:0]           usage_q, usage_d;
    logic [NR_PORTS-1:0]     done_q, done_d;
    logic                    overflow_q, overflow_d;
    logic [DROP_CNT_LEN-1:0] drop_cnt_q, drop_cnt_d;

    logic [NR_PORTS-1:0] active;
    logic                capture, push, pop, drop, hs, last;
    logic [NR_PORTS-1:0] rem, sel_oh;

    always_comb begin
        for (int p = 0; p < NR_PORTS; p++) begin
            active[p] = iretire_i[p] | (|itype_i[p*ITYPE_LEN +: ITYPE_LEN]);
        end
    end

    assign capture = |active;
    assign ready_o = (usage_q != FULL_CNT);
    assign valid_o = (usage_q != '0);

    // rem is the head slot's active mask minus the ports already emitted; a slot's mask is never 0.
    assign rem    = mem_mask_q[rd_ptr_q] & ~done_q;
    assign sel_oh = rem & (~rem + NR_PORTS'(1));
    assign last   = ((rem & ~sel_oh) == '0);

    // valid/ready: a uop transfers on every edge where valid_o && ready_i; while valid_o is high
    // and ready_i low, all outputs hold. valid_o never depends on ready_i.
    assign hs   = valid_o & ready_i;
    assign pop  = hs & last;
    assign push = capture & ready_o;
    assign drop = capture & ~ready_o;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        usage_d    = usage_q;
        if (push && !pop) begin
            usage_d = usage_q + UW'(1);
        end else if (!push && pop) begin
            usage_d = usage_q - UW'(1);
        end
        done_d = done_q;
        if (pop) begin
            done_d = '0;
        end else if (hs) begin
            done_d = done_q | sel_oh;
        end
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_ovf_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (!(&drop_cnt_q)) begin
                drop_cnt_d = drop_cnt_q + DROP_CNT_LEN'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usage_q    <= '0;
            done_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            usage_q    <= usage_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Slot contents need no reset: they are only visible while usage_q says the slot is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_ret_q[wr_ptr_q]   <= iretire_i;
            mem_mask_q[wr_ptr_q]  <= active;
            mem_ils_q[wr_ptr_q]   <= ilastsize_i;
            mem_itype_q[wr_ptr_q] <= itype_i;
            mem_iaddr_q[wr_ptr_q] <= iaddr_i;
            mem_cause_q[wr_ptr_q] <= cause_i;
            mem_tval_q[wr_ptr_q]  <= tval_i;
            mem_priv_q[wr_ptr_q]  <= priv_i;
        end
    end

    always_comb begin
        iretire_o   = 1'b0;
        ilastsize_o = '0;
        itype_o     = '0;
        iaddr_o     = '0;
        cause_o     = '0;
        tval_o      = '0;
        priv_o      = '0;
        if (valid_o) begin
            for (int p = 0; p < NR_PORTS; p++) begin
                if (sel_oh[p]) begin
                    iretire_o   = mem_ret_q[rd_ptr_q][p];
                    ilastsize_o = mem_ils_q[rd_ptr_q][p*ILASTSIZE_LEN +: ILASTSIZE_LEN];
                    itype_o     = mem_itype_q[rd_ptr_q][p*ITYPE_LEN +: ITYPE_LEN];
                    iaddr_o     = mem_iaddr_q[rd_ptr_q][p*XLEN +: XLEN];
                end
            end
            cause_o = mem_cause_q[rd_ptr_q];
            tval_o  = mem_tval_q[rd_ptr_q];
            priv_o  = mem_priv_q[rd_ptr_q];
        end
    end

    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_retire_serializer.sv
// Bench for retire_serializer: directed vector table, hand-written corner sequences and
// randomized traffic checked against a uop-queue reference model.
module tb_retire_serializer;

    localparam int DEPTH = 16;

    logic          clk_i;
    logic          rst_ni;
    logic [1:0]    iretire_i;
    logic [1:0]    ilastsize_i;
    logic [5:0]    itype_i;
    logic [127:0]  iaddr_i;
    logic [4:0]    cause_i;
    logic [63:0]   tval_i;
    logic [1:0]    priv_i;
    logic          ready_o;
    logic          valid_o;
    logic          ready_i;
    logic          iretire_o;
    logic [0:0]    ilastsize_o;
    logic [2:0]    itype_o;
    logic [63:0]   iaddr_o;
    logic [4:0]    cause_o;
    logic [63:0]   tval_o;
    logic [1:0]    priv_o;
    logic          clear_ovf_i;
    logic          overflow_o;
    logic [7:0]    drop_cnt_o;

    retire_serializer dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .iretire_i(iretire_i), .ilastsize_i(ilastsize_i), .itype_i(itype_i), .iaddr_i(iaddr_i),
        .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i),
        .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i),
        .iretire_o(iretire_o), .ilastsize_o(ilastsize_o), .itype_o(itype_o), .iaddr_o(iaddr_o),
        .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o),
        .clear_ovf_i(clear_ovf_i), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        ret;
        logic        ils;
        logic [2:0]  ity;
        logic [63:0] addr;
        logic [4:0]  cause;
        logic [63:0] tval;
        logic [1:0]  priv;
        logic        last;
    } uop_t;

    uop_t exp_q[$];
    int   slot_cnt;
    logic m_ovf;
    int   m_drop;

    int n_cmp;
    int n_err;
    int cyc;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    task automatic model_reset();
        exp_q.delete();
        slot_cnt = 0;
        m_ovf    = 1'b0;
        m_drop   = 0;
    endtask

    task automatic check_outputs();
        uop_t f;
        chk("ready_o", 64'(ready_o), 64'(slot_cnt != DEPTH));
        chk("valid_o", 64'(valid_o), 64'(exp_q.size() > 0));
        chk("overflow_o", 64'(overflow_o), 64'(m_ovf));
        chk("drop_cnt_o", 64'(drop_cnt_o), 64'(m_drop));
        f = '0;
        if (exp_q.size() > 0) f = exp_q[0];
        chk("iretire_o", 64'(iretire_o), 64'(f.ret));
        chk("ilastsize_o", 64'(ilastsize_o), 64'(f.ils));
        chk("itype_o", 64'(itype_o), 64'(f.ity));
        chk("iaddr_o", iaddr_o, f.addr);
        chk("cause_o", 64'(cause_o), 64'(f.cause));
        chk("tval_o", tval_o, f.tval);
        chk("priv_o", 64'(priv_o), 64'(f.priv));
    endtask

    // ---------------- driver: one clock cycle, entered and left just after a negedge ----------------
    task automatic cycle(input logic [1:0] ret, input logic [5:0] ity, input logic [127:0] addr,
                         input logic rdy, input logic clr);
        logic [1:0] act;
        logic       full;
        uop_t       u;
        iretire_i   = ret;
        itype_i     = ity;
        iaddr_i     = addr;
        ilastsize_i = 2'($urandom_range(0, 3));
        cause_i     = 5'($urandom_range(0, 31));
        tval_i      = {$urandom, $urandom};
        priv_i      = 2'($urandom_range(0, 3));
        ready_i     = rdy;
        clear_ovf_i = clr;
        #1;
        check_outputs();
        full = (slot_cnt == DEPTH);
        for (int p = 0; p < 2; p++) act[p] = ret[p] | (ity[p*3 +: 3] != 3'd0);
        if (exp_q.size() > 0 && rdy) begin
            u = exp_q.pop_front();
            if (u.last) slot_cnt--;
        end
        if (act != 2'b00 && !full) begin
            for (int p = 0; p < 2; p++) begin
                if (act[p]) begin
                    u.ret   = ret[p];
                    u.ils   = ilastsize_i[p];
                    u.ity   = ity[p*3 +: 3];
                    u.addr  = addr[p*64 +: 64];
                    u.cause = cause_i;
                    u.tval  = tval_i;
                    u.priv  = priv_i;
                    u.last  = ((act >> (p + 1)) == 2'b00);
                    exp_q.push_back(u);
                end
            end
            slot_cnt++;
        end
        if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end else if (act != 2'b00 && full) begin
            m_ovf  = 1'b1;
            m_drop = (m_drop == 255) ? 255 : m_drop + 1;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic idle(input logic rdy);
        cycle(2'b00, 6'd0, 128'd0, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) idle(1'b1);
        chk("drain_empty", 64'(valid_o), 64'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]   ret;
        logic [5:0]   ity;
        logic [127:0] addr;
        logic         rdy;
        logic         exp_valid;
        logic [63:0]  exp_addr;
        logic [2:0]   exp_ity;
    } vec_t;

    vec_t vt[14];

    initial begin
        vt[0]  = '{2'b11, 6'd0, {64'h104, 64'h100}, 1'b1, 1'b0, 64'h0, 3'd0};
        vt[1]  = '{2'b00, 6'd0, 128'd0, 1'b1, 1'b1, 64'h100, 3'd0};
        vt[2]  = '{2'b00, 6'd0, 128'd0, 1'b1, 1'b1, 64'h104, 3'd0};
        vt[3]  = '{2'b00, 6'd0, 128'd0, 1'b1, 1'b0, 64'h0, 3'd0};
        vt[4]  = '{2'b10, 6'd0, {64'h200, 64'h2000}, 1'b1, 1'b0, 64'h0, 3'd0};
        vt[5]  = '{2'b00, 6'd0, 128'd0, 1'b1, 1'b1, 64'h200, 3'd0};
        vt[6]  = '{2'b00, 6'd0, 128'd0, 1'b1, 1'b0, 64'h0, 3'd0};
        vt[7]  = '{2'b00, {3'd0, 3'd5}, {64'h0, 64'h300}, 1'b1, 1'b0, 64'h0, 3'd0};
        vt[8]  = '{2'b00, 6'd0, 128'd0, 1'b1, 1'b1, 64'h300, 3'd5};
        vt[9]  = '{2'b00, 6'd0, 128'd0, 1'b1, 1'b0, 64'h0, 3'd0};
        vt[10] = '{2'b01, 6'd0, {64'h0, 64'h400}, 1'b1, 1'b0, 64'h0, 3'd0};
        vt[11] = '{2'b01, 6'd0, {64'h0, 64'h404}, 1'b1, 1'b1, 64'h400, 3'd0};
        vt[12] = '{2'b00, 6'd0, 128'd0, 1'b1, 1'b1, 64'h404, 3'd0};
        vt[13] = '{2'b00, 6'd0, 128'd0, 1'b1, 1'b0, 64'h0, 3'd0};
    end

    // ---------------- test sequence ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        model_reset();
        rst_ni      = 1'b0;
        iretire_i   = '0;
        ilastsize_i = '0;
        itype_i     = '0;
        iaddr_i     = '0;
        cause_i     = '0;
        tval_i      = '0;
        priv_i      = '0;
        ready_i     = 1'b0;
        clear_ovf_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check_outputs();
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Directed table: single/partial/itype-only captures and back-to-back slots.
        for (int i = 0; i < 14; i++) begin
            chk("tbl_valid", 64'(valid_o), 64'(vt[i].exp_valid));
            chk("tbl_iaddr", iaddr_o, vt[i].exp_addr);
            chk("tbl_itype", 64'(itype_o), 64'(vt[i].exp_ity));
            cycle(vt[i].ret, vt[i].ity, vt[i].addr, vt[i].rdy, 1'b0);
        end

        // Continuous 2-uop captures at 1 uop/cycle drain: fills after 30 cycles, then drops alternate.
        for (int i = 0; i < 40; i++) cycle(2'b11, 6'd0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        chk("fill_ready", 64'(ready_o), 64'd0);
        chk("fill_ovf", 64'(overflow_o), 64'd1);
        chk("fill_drop", 64'(drop_cnt_o), 64'd5);

        // 300 more drops with a stalled consumer: counter saturates.
        for (int i = 0; i < 300; i++) cycle(2'b01, 6'd0, 128'd7, 1'b0, 1'b0);
        chk("sat_drop", 64'(drop_cnt_o), 64'd255);
        chk("sat_ovf", 64'(overflow_o), 64'd1);
        cycle(2'b01, 6'd0, 128'd9, 1'b0, 1'b1);
        chk("clr_drop", 64'(drop_cnt_o), 64'd0);
        chk("clr_ovf", 64'(overflow_o), 64'd0);
        idle(1'b0);
        chk("clr_hold", 64'(drop_cnt_o), 64'd0);
        drain();

        // Stall: outputs hold for 5 cycles, then the same uop is accepted exactly once.
        cycle(2'b11, 6'd0, {64'h504, 64'h500}, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(valid_o), 64'd1);
            chk("stall_iaddr", iaddr_o, 64'h500);
            idle(1'b0);
        end
        idle(1'b1);
        chk("release_next", iaddr_o, 64'h504);
        idle(1'b1);
        chk("release_done", 64'(valid_o), 64'd0);

        // Reset with 3 slots queued: immediate return to reset values, nothing stale afterwards.
        for (int i = 0; i < 3; i++) cycle(2'b01, 6'd0, 128'(64'h600 + i), 1'b0, 1'b0);
        rst_ni = 1'b0;
        #1;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_iaddr", iaddr_o, 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("post_rst_valid", 64'(valid_o), 64'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [1:0] r;
            logic [5:0] t;
            r = ($urandom_range(0, 9) < 3) ? 2'b00 : 2'($urandom_range(0, 3));
            t[2:0] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            t[5:3] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            cycle(r, t, {$urandom, $urandom, $urandom, $urandom},
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
